// File: rtl/program_counter_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | program_counter_stack: WIDTH-bit PC with jump, relative branch and        |
// | call/return through an internal LIFO, tri-state bus output and flags.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module program_counter_stack #(
  parameter int                 WIDTH       = 8,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0]   RESET_VEC   = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] in,
  input  logic             oe,
  input  logic             jmp,
  input  logic             call,
  input  logic             ret,
  input  logic             rel,
  input  logic             inc,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] pc_q,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err,
  output logic             wrap
);

  localparam int c_cnt_w = $clog2(STACK_DEPTH + 1);
  localparam int c_idx_w = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(STACK_DEPTH);

  logic [WIDTH-1:0]   pc_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               wrap_q, wrap_d;
  logic               push;
  logic [WIDTH-1:0]   pc_inc;
  logic [c_cnt_w-1:0] cnt_m1;
  logic [c_idx_w-1:0] wr_idx, rd_idx;
  logic [WIDTH-1:0]   stack_q [STACK_DEPTH];

  assign pc_inc    = pc_q + 1'b1;
  assign cnt_m1    = cnt_q - 1'b1;
  assign wr_idx    = cnt_q[c_idx_w-1:0];
  assign rd_idx    = cnt_m1[c_idx_w-1:0];
  assign stk_full  = (cnt_q == c_cnt_full);
  assign stk_empty = (cnt_q == '0);
  assign stk_err   = err_q;
  assign wrap      = wrap_q;
  assign out       = oe ? pc_q : {WIDTH{1'bz}};

  // Priority chain: only the highest asserted command acts.
  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    wrap_d = 1'b0;
    push   = 1'b0;
    if (jmp) begin
      pc_d = in;
    end else if (call) begin
      if (stk_full) begin
        err_d = 1'b1;
      end else begin
        push  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        pc_d  = in;
      end
    end else if (ret) begin
      if (stk_empty) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_m1;
        pc_d  = stack_q[rd_idx];
      end
    end else if (rel) begin
      pc_d = pc_q + in;
    end else if (inc) begin
      pc_d   = pc_inc;
      wrap_d = &pc_q;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q   <= RESET_VEC;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      wrap_q <= wrap_d;
    end
  end

  // Entries are deliberately not reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      stack_q[wr_idx] <= pc_inc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_counter_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_program_counter_stack: directed + randomized bench against a          |
// | queue-based reference model of the PC and its return stack.  Rev 1.0     |
// +--------------------------------------------------------------------------+
module tb_program_counter_stack;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         clr, oe, jmp, call, ret, rel, inc;
  logic [W-1:0] in_v;
  wire  [W-1:0] out;
  logic [W-1:0] pc_q;
  logic         stk_full, stk_empty, stk_err, wrap;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk[$];
  logic         m_err, m_wrap;
  logic [W-1:0] zval;

  program_counter_stack #(.WIDTH(W), .STACK_DEPTH(D), .RESET_VEC(8'h00)) dut (
    .clk(clk), .clr(clr), .in(in_v), .oe(oe), .jmp(jmp), .call(call),
    .ret(ret), .rel(rel), .inc(inc), .out(out), .pc_q(pc_q),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 8'h00;
    m_stk.delete();
    m_err  = 1'b0;
    m_wrap = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] ra;
    m_wrap = 1'b0;
    if (jmp) begin
      m_pc = in_v;
    end else if (call) begin
      if (m_stk.size() == D) m_err = 1'b1;
      else begin
        ra = m_pc + 8'd1;
        m_stk.push_back(ra);
        m_pc = in_v;
      end
    end else if (ret) begin
      if (m_stk.size() == 0) m_err = 1'b1;
      else m_pc = m_stk.pop_back();
    end else if (rel) begin
      m_pc = m_pc + in_v;
    end else if (inc) begin
      if (m_pc == 8'hFF) m_wrap = 1'b1;
      m_pc = m_pc + 8'd1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    16'(pc_q), 16'(m_pc));
    check({tag, ".out"},   16'(out), oe ? 16'(m_pc) : 16'(zval));
    check({tag, ".full"},  16'(stk_full), 16'(m_stk.size() == D));
    check({tag, ".empty"}, 16'(stk_empty), 16'(m_stk.size() == 0));
    check({tag, ".err"},   16'(stk_err), 16'(m_err));
    check({tag, ".wrap"},  16'(wrap), 16'(m_wrap));
  endtask

  // One clock: drive at negedge, model the rising edge, check 1 unit later.
  task automatic cyc(input string tag, input logic j, input logic c, input logic r,
                     input logic rl, input logic i, input logic [W-1:0] d);
    @(negedge clk);
    jmp = j; call = c; ret = r; rel = rl; inc = i; in_v = d;
    @(posedge clk);
    if (!clr) model_edge();
    #1 check_all(tag);
  endtask

  // Async clear asserted mid-cycle while random commands are being driven.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    {jmp, call, ret, rel, inc} = 5'($urandom);
    in_v = 8'($urandom);
    #2 clr = 1'b1;
    model_reset();
    #1 check_all({tag, ".async"});
    @(posedge clk);
    #1 check_all({tag, ".held"});
    @(negedge clk);
    clr = 1'b0;
    {jmp, call, ret, rel, inc} = 5'b0;
  endtask

  initial begin
    zval = 'z;
    clr = 1'b1; oe = 1'b1; jmp = 0; call = 0; ret = 0; rel = 0; inc = 0; in_v = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) clr = 1'b0;

    // 1: reset state and output enable
    cyc("t1_move", 1, 0, 0, 0, 0, 8'h37);
    reset_pulse("t1_rst");
    check("t1_pc0", 16'(pc_q), 16'h0000);
    @(negedge clk) oe = 1'b0;
    #1 check("t1_outz", 16'(out), 16'(zval));
    oe = 1'b1;
    #1 check("t1_out0", 16'(out), 16'h0000);

    // 2: inc rollover and jmp priority over inc
    cyc("t2_jfe", 1, 0, 0, 0, 0, 8'hFE);
    cyc("t2_inc1", 0, 0, 0, 0, 1, 8'h00);
    cyc("t2_inc2", 0, 0, 0, 0, 1, 8'h00);
    check("t2_wrap1", 16'(wrap), 16'h0001);
    cyc("t2_idle", 0, 0, 0, 0, 0, 8'h00);
    check("t2_wrap0", 16'(wrap), 16'h0000);
    cyc("t2_jinc", 1, 0, 0, 0, 1, 8'h40);
    check("t2_j40", 16'(pc_q), 16'h0040);

    // 3: nested call/return
    cyc("t3_j10", 1, 0, 0, 0, 0, 8'h10);
    cyc("t3_c80", 0, 1, 0, 0, 0, 8'h80);
    cyc("t3_ca0", 0, 1, 0, 0, 0, 8'hA0);
    cyc("t3_r1", 0, 0, 1, 0, 0, 8'h00);
    check("t3_81", 16'(pc_q), 16'h0081);
    cyc("t3_r2", 0, 0, 1, 0, 0, 8'h00);
    check("t3_11", 16'(pc_q), 16'h0011);

    // 4: overflow
    cyc("t4_j00", 1, 0, 0, 0, 0, 8'h00);
    for (int k = 0; k < D; k++) cyc("t4_call", 0, 1, 0, 0, 0, 8'(8'h20 + 8'(k) * 8'h10));
    check("t4_full", 16'(stk_full), 16'h0001);
    cyc("t4_ovf", 0, 1, 0, 0, 0, 8'h33);
    check("t4_err", 16'(stk_err), 16'h0001);
    cyc("t4_r1", 0, 0, 1, 0, 0, 8'h00);
    check("t4_41", 16'(pc_q), 16'h0041);
    for (int k = 1; k < D; k++) cyc("t4_ret", 0, 0, 1, 0, 0, 8'h00);
    check("t4_01", 16'(pc_q), 16'h0001);
    reset_pulse("t4_rst");

    // 5: underflow is sticky
    cyc("t5_j2c", 1, 0, 0, 0, 0, 8'h2C);
    cyc("t5_ret", 0, 0, 1, 0, 0, 8'h00);
    check("t5_pc", 16'(pc_q), 16'h002C);
    cyc("t5_jmp", 1, 0, 0, 0, 0, 8'h60);
    cyc("t5_inc", 0, 0, 0, 0, 1, 8'h00);
    check("t5_sticky", 16'(stk_err), 16'h0001);
    reset_pulse("t5_rst");

    // 6: relative branch
    cyc("t6_j05", 1, 0, 0, 0, 0, 8'h05);
    cyc("t6_relm3", 0, 0, 0, 1, 0, 8'hFD);
    check("t6_02", 16'(pc_q), 16'h0002);
    cyc("t6_j90", 1, 0, 0, 0, 0, 8'h90);
    cyc("t6_rel7f", 0, 0, 0, 1, 0, 8'h7F);
    check("t6_0f", 16'(pc_q), 16'h000F);
    cyc("t6_relinc", 0, 0, 0, 1, 1, 8'h02);
    check("t6_11", 16'(pc_q), 16'h0011);

    // randomized mix, sparse commands so the stack fills and drains
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        reset_pulse("rnd_rst");
      end else begin
        oe = 1'($urandom);
        cyc("rnd", ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
